// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl
// -------------
// Session controller for a small processor with a writable program memory.
// A start pulse opens a session: program words are accepted on a valid/ready
// load port and written to memory one word per cycle. The word flagged
// ld_last ends the load; one FLUSH cycle lets that final write land. The core
// is then released (core_run) and the controller counts run cycles until the
// core reports HALTED (done) or the optional cycle limit expires (timed_out).
//
// Ports
//   clk1           single clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   start          one-cycle pulse; honoured only when no session is active
//   ld_valid       load word offered
//   ld_ready       controller accepts load words (LOAD state only)
//   ld_addr        target word address of the offered word
//   ld_data        offered word
//   ld_last        offered word is the final one of the program
//   mem_we         one-cycle memory write strobe per accepted word
//   mem_addr       memory write address (holds between writes)
//   mem_wdata      memory write data (holds between writes)
//   timeout_limit  maximum run cycles, 0 disables the limit; sampled every cycle
//   core_halted    HALTED flag from the core
//   core_run       releases the core; while low the core holds PC/flags cleared
//   busy           session in progress (LOAD, FLUSH, RUN)
//   done           sticky: core halted normally
//   timed_out      sticky: run limit reached before halt
//   cycle_count    cycles spent in RUN, saturating
//   load_count     words accepted in this session, saturating at 2**ADDR_W

module prog_run_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [CNT_W-1:0]  timeout_limit,
    input  logic              core_halted,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_TMO   = 3'd5
    } state_t;

    // load_count tops out at exactly 2**ADDR_W (one full memory image).
    localparam logic [ADDR_W:0]  LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state;

    logic handshake;
    logic limit_hit;

    assign handshake = ld_valid & ld_ready;

    // Limit compare uses the live timeout_limit so a mid-run change applies at
    // once. A limit below the current count simply never matches.
    assign limit_hit = (timeout_limit != '0) &&
                       (cycle_count == timeout_limit - CNT_W'(1));

    // Outputs are registered alongside the state so every output changes on
    // the same edge as the state it belongs to.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of the
    // order the statements appear in.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= S_IDLE;
            ld_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_run    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            load_count  <= '0;
        end else begin
            // NOTE: the write strobe defaults low every cycle and is raised
            // only by a handshake, so it is a single-cycle pulse by
            // construction; address and data keep their last value.
            mem_we <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ld_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timed_out   <= 1'b0;
                        cycle_count <= '0;
                        load_count  <= '0;
                    end
                end

                S_LOAD: begin
                    if (handshake) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_data;
                        if (load_count != LOAD_MAX) begin
                            load_count <= load_count + (ADDR_W+1)'(1);
                        end
                        if (ld_last) begin
                            state    <= S_FLUSH;
                            ld_ready <= 1'b0;
                        end
                    end
                end

                // The final write is on the memory port during this cycle;
                // the core is released only once it has landed.
                S_FLUSH: begin
                    state    <= S_RUN;
                    core_run <= 1'b1;
                end

                S_RUN: begin
                    // Counts on every RUN edge, including the one that leaves
                    // RUN, so the final value equals the number of RUN cycles.
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    // Halt is tested first: a halt on the limit edge is a
                    // normal completion, not a timeout.
                    if (core_halted) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        core_run <= 1'b0;
                        busy     <= 1'b0;
                    end else if (limit_hit) begin
                        state     <= S_TMO;
                        timed_out <= 1'b1;
                        core_run  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    ld_ready <= 1'b0;
                    core_run <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: sessions with randomized program words, limits and
// halt points are checked against expectations derived from the session rules
// (which of halt/limit comes first, saturating counts, ordered write list).

module tb_prog_run_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int WW     = ADDR_W + DATA_W;

    logic              clk1;
    logic              rst;
    logic              start;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [CNT_W-1:0]  timeout_limit;
    logic              core_halted;
    logic              core_run;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_count;
    logic [ADDR_W:0]   load_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WW-1:0] got_q[$];
    logic [WW-1:0] exp_q[$];

    prog_run_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk1          (clk1),
        .rst           (rst),
        .start         (start),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .timeout_limit (timeout_limit),
        .core_halted   (core_halted),
        .core_run      (core_run),
        .busy          (busy),
        .done          (done),
        .timed_out     (timed_out),
        .cycle_count   (cycle_count),
        .load_count    (load_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Memory-side observer: every cycle with the strobe high is one write.
    always @(negedge clk1) begin
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // One full session. limit/halt_at describe the run: halt_at = k means the
    // core raises HALTED during its k-th RUN cycle (0 = never). If chg_at > 0
    // the limit is rewritten to chg_limit during RUN cycle chg_at.
    task automatic run_session(input string tag, input int n, input int limit,
                               input int halt_at, input bit gaps, input bit poke,
                               input int chg_at, input int chg_limit);
        int rc;
        int j;
        int base;
        int eff;
        int exp_run;
        bit exp_done;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  exp_cnt;
        logic [ADDR_W:0]   exp_lc;

        got_q.delete();
        exp_q.delete();
        timeout_limit = CNT_W'(limit);
        core_halted   = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b1 || load_count !== '0 ||
            cycle_count !== '0 || done !== 1'b0 || timed_out !== 1'b0 || core_run !== 1'b0)
            $display("FAIL %s entry: ready=%b busy=%b lc=%0d cc=%0d done=%b tmo=%b run=%b, want 1 1 0 0 0 0 0",
                     tag, ld_ready, busy, load_count, cycle_count, done, timed_out, core_run);
        else n_pass++;

        base = $urandom_range(0, (1 << ADDR_W) - 1);
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(base + i);
            d = $urandom;
            exp_q.push_back({a, d});
            ld_valid = 1'b1;
            ld_addr  = a;
            ld_data  = d;
            ld_last  = (i == n - 1);
            j = 0;
            while (ld_ready !== 1'b1 && j < 5) begin
                tick();
                j++;
            end
            if (ld_ready !== 1'b1) begin
                n_checks++;
                $display("FAIL %s ld_ready for word %0d: got %b want 1", tag, i, ld_ready);
            end
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (gaps && i != n - 1) begin
                start = poke;
                tick();
                start = 1'b0;
            end
        end

        j = 0;
        while (core_run !== 1'b1 && j < 10) begin
            tick();
            j++;
        end
        n_checks++;
        if (core_run !== 1'b1) $display("FAIL %s run entry: core_run=%b want 1", tag, core_run);
        else n_pass++;

        rc = (core_run === 1'b1) ? 1 : 0;
        while (rc > 0 && rc < 80000) begin
            if (rc == halt_at) core_halted = 1'b1;
            if (rc == chg_at) timeout_limit = CNT_W'(chg_limit);
            start = (poke && rc == 2);
            tick();
            core_halted = 1'b0;
            start       = 1'b0;
            if (core_run !== 1'b1) break;
            rc++;
        end
        repeat (2) tick();

        // Reference: whichever of halt and limit comes first ends the run;
        // a halt on the limit cycle counts as a normal completion.
        eff      = (chg_at > 0) ? chg_limit : limit;
        exp_done = (halt_at != 0) && (eff == 0 || halt_at <= eff);
        exp_run  = exp_done ? halt_at : eff;
        exp_cnt  = CNT_W'((exp_run > 65535) ? 65535 : exp_run);
        exp_lc   = (ADDR_W+1)'((n > (1 << ADDR_W)) ? (1 << ADDR_W) : n);

        n_checks++;
        if (rc !== exp_run) $display("FAIL %s run length: got %0d cycles want %0d", tag, rc, exp_run);
        else n_pass++;
        n_checks++;
        if (done !== exp_done || timed_out !== !exp_done)
            $display("FAIL %s outcome: done=%b timed_out=%b want %b %b", tag, done, timed_out, exp_done, !exp_done);
        else n_pass++;
        n_checks++;
        if (cycle_count !== exp_cnt) $display("FAIL %s cycle_count: got %0d want %0d", tag, cycle_count, exp_cnt);
        else n_pass++;
        n_checks++;
        if (load_count !== exp_lc) $display("FAIL %s load_count: got %0d want %0d", tag, load_count, exp_lc);
        else n_pass++;
        n_checks++;
        if (core_run !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL %s idle outputs: run=%b busy=%b ready=%b we=%b want 0 0 0 0",
                     tag, core_run, busy, ld_ready, mem_we);
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata} !== exp_q[$])
            $display("FAIL %s held write: got %h want %h", tag, {mem_addr, mem_wdata}, exp_q[$]);
        else n_pass++;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL %s write count: got %0d want %0d", tag, got_q.size(), exp_q.size());
        end else begin
            j = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (got_q[i] !== exp_q[i] && j == 0) begin
                    $display("FAIL %s write %0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
                    j = 1;
                end
            end
            if (j == 0) n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        ld_valid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({ld_ready, mem_we, core_run, busy, done, timed_out} !== 6'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || cycle_count !== '0 || load_count !== '0)
            $display("FAIL reset state: flags=%b addr=%h data=%h cc=%0d lc=%0d want all 0",
                     {ld_ready, mem_we, core_run, busy, done, timed_out}, mem_addr, mem_wdata,
                     cycle_count, load_count);
        else n_pass++;
        start = 1'b0;
        ld_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL idle after reset: busy=%b ready=%b want 0 0", busy, ld_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        got_q.delete();
        timeout_limit = 16'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_addr  = ADDR_W'(i + 100);
            ld_data  = 32'hA500_0000 + i;
            ld_last  = 1'b0;
            tick();
        end
        ld_addr = ADDR_W'(102);
        ld_data = 32'hA500_0002;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_valid = 1'b0;
        n_checks++;
        if ({ld_ready, mem_we, core_run, busy, done, timed_out} !== 6'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || load_count !== '0 || cycle_count !== '0)
            $display("FAIL midload reset: flags=%b addr=%h data=%h lc=%0d cc=%0d want all 0",
                     {ld_ready, mem_we, core_run, busy, done, timed_out}, mem_addr, mem_wdata,
                     load_count, cycle_count);
        else n_pass++;
        tick();
        n_checks++;
        if (got_q.size() != 2) $display("FAIL midload writes: got %0d want 2", got_q.size());
        else n_pass++;
        run_session("after_reset", 3, 1000, 7, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_midrun();
        timeout_limit = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = '0;
        ld_data  = 32'h1234_5678;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (core_run !== 1'b0 || busy !== 1'b0 || cycle_count !== '0 || load_count !== '0)
            $display("FAIL midrun reset: run=%b busy=%b cc=%0d lc=%0d want 0 0 0 0",
                     core_run, busy, cycle_count, load_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int n;
        int lim;
        int h;
        for (int s = 0; s < 8; s++) begin
            n   = $urandom_range(1, 12);
            lim = $urandom_range(0, 40);
            h   = $urandom_range(1, 50);
            if (lim != 0 && $urandom_range(0, 3) == 0) h = 0;
            run_session("random", n, lim, h, $urandom_range(0, 1), 1'b0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        ld_last = 1'b0; timeout_limit = '0; core_halted = 1'b0;

        test_reset();
        run_session("load11_halt60", 11, 1000, 60, 1'b0, 1'b0, 0, 0);
        run_session("timeout5", 1, 5, 0, 1'b0, 1'b0, 0, 0);
        run_session("halt_on_limit", 1, 5, 5, 1'b0, 1'b0, 0, 0);
        run_session("halt_after_limit", 2, 5, 6, 1'b0, 1'b0, 0, 0);
        run_session("gaps_start_poke", 4, 1000, 8, 1'b1, 1'b1, 0, 0);
        run_session("limit_change", 3, 1000, 0, 1'b0, 1'b0, 2, 6);
        run_session("limit_one", 1, 1, 0, 1'b0, 1'b0, 0, 0);
        run_session("load_sat", 1030, 1, 0, 1'b0, 1'b0, 0, 0);
        test_reset_midload();
        test_reset_midrun();
        test_random();
        run_session("cycle_sat", 2, 0, 70000, 1'b0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
